// File: rtl/mcu_core_seq.sv
// Sequential fetch/decode/execute MCU core: 4 GPRs, ALU, PC/IR, one I/O port pair, req/ack memory bus.
// Defining MCU_MEM_TIMEOUT_EN adds a bounded ack wait that raises a sticky mem_err and halts the core.
module mcu_core_seq #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int PC_RESET    = 0,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] p_in,
    output logic [DATA_W-1:0] p_out,
    output logic              p_out_vld,
    output logic              halted,
    output logic              mem_err
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_HALTED
    } state_t;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_XOR  = 4'h5,
        OP_NOT  = 4'h6,
        OP_MOV  = 4'h7,
        OP_LDI  = 4'h8,
        OP_LD   = 4'h9,
        OP_ST   = 4'hA,
        OP_IN   = 4'hB,
        OP_OUT  = 4'hC,
        OP_JMP  = 4'hD,
        OP_JZ   = 4'hE,
        OP_HALT = 4'hF
    } op_t;

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] pc;
    logic [15:0]       ir;
    logic [DATA_W-1:0] gpr [4];
    logic [DATA_W-1:0] opnd_d;
    logic [DATA_W-1:0] opnd_s;
    logic [DATA_W-1:0] alu_res;
    logic              alu_we;
    logic              req_c;
    logic              timeout;
    op_t               op;
    logic [1:0]        rd;
    logic [1:0]        rs;

    assign op = op_t'(ir[15:12]);
    assign rd = ir[11:10];
    assign rs = ir[9:8];

    // The bus is owned only in FETCH and MEM; address and data come from registers, so they
    // cannot move while an access waits for its ack.
    assign req_c     = (state == S_FETCH) || (state == S_MEM);
    assign mem_req   = req_c && rst;
    assign mem_we    = (state == S_MEM) && (op == OP_ST) && rst;
    assign mem_addr  = (state == S_MEM) ? ADDR_W'(opnd_s) : pc;
    assign mem_wdata = (state == S_MEM) ? opnd_d : '0;
    assign halted    = (state == S_HALTED);

`ifdef MCU_MEM_TIMEOUT_EN
    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

    logic [WAIT_W-1:0] wait_cnt;
    logic              mem_err_q;

    // An ack arriving in the expiry cycle completes the access instead of faulting.
    assign timeout = req_c && !mem_ack && (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));
    assign mem_err = mem_err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt  <= '0;
            mem_err_q <= 1'b0;
        end else begin
            if (!req_c || mem_ack) begin
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
            if (timeout) begin
                mem_err_q <= 1'b1;
            end
        end
    end
`else
    assign timeout = 1'b0;
    assign mem_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_FETCH;
        end else begin
            // NOTE: state elements are written with non-blocking assignments so every flop
            // samples the pre-edge values, independent of process ordering.
            state <= state_nx;
        end
    end

    always_comb begin
        // NOTE: default assignment first; any path that skipped it would infer a latch.
        state_nx = state;
        case (state)
            S_FETCH:  if (mem_ack) state_nx = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LD, OP_ST: state_nx = S_MEM;
                    OP_HALT:      state_nx = S_HALTED;
                    default:      state_nx = S_EXEC;
                endcase
            end
            S_EXEC:   state_nx = S_FETCH;
            S_MEM:    if (mem_ack) state_nx = S_FETCH;
            S_HALTED: state_nx = S_HALTED;
            default:  state_nx = S_FETCH;
        endcase
        if (timeout) begin
            state_nx = S_HALTED;
        end
    end

    always_comb begin
        alu_res = opnd_d;
        alu_we  = 1'b1;
        case (op)
            OP_ADD:  alu_res = opnd_d + opnd_s;
            OP_SUB:  alu_res = opnd_d - opnd_s;
            OP_AND:  alu_res = opnd_d & opnd_s;
            OP_OR:   alu_res = opnd_d | opnd_s;
            OP_XOR:  alu_res = opnd_d ^ opnd_s;
            OP_NOT:  alu_res = ~opnd_s;
            OP_MOV:  alu_res = opnd_s;
            OP_LDI:  alu_res = DATA_W'(ir[7:0]);
            OP_IN:   alu_res = p_in;
            default: alu_we  = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc        <= ADDR_W'(PC_RESET);
            ir        <= '0;
            opnd_d    <= '0;
            opnd_s    <= '0;
            p_out     <= '0;
            p_out_vld <= 1'b0;
            // NOTE: the register file is only four words, so it is cleared like any other
            // flop; larger storage arrays would normally be left unreset.
            for (int i = 0; i < 4; i++) begin
                gpr[i] <= '0;
            end
        end else begin
            p_out_vld <= 1'b0;
            case (state)
                S_FETCH: begin
                    if (mem_ack) begin
                        ir <= mem_rdata[15:0];
                        pc <= pc + ADDR_W'(1);
                    end
                end
                S_DECODE: begin
                    opnd_d <= gpr[rd];
                    opnd_s <= gpr[rs];
                end
                S_EXEC: begin
                    if (alu_we) begin
                        gpr[rd] <= alu_res;
                    end
                    if (op == OP_OUT) begin
                        p_out     <= opnd_d;
                        p_out_vld <= 1'b1;
                    end
                    // Jumps override the increment already applied during fetch.
                    if ((op == OP_JMP) || ((op == OP_JZ) && (opnd_d == '0))) begin
                        pc <= ADDR_W'(opnd_s);
                    end
                end
                S_MEM: begin
                    if (mem_ack && (op == OP_LD)) begin
                        gpr[rd] <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
